// File: rtl/aes_round_sequencer.sv
// AES block control FSM: steps one block through AddRoundKey/SubBytes/ShiftRows/MixColumns
// units, tracking round number and round-key index, with a per-step watchdog.
module aes_round_sequencer #(
  parameter int unsigned NR      = 10,
  parameter int unsigned RND_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             ark_done,
  input  logic             sb_done,
  input  logic             sr_done,
  input  logic             mc_done,
  output logic             ark_en,
  output logic             sb_en,
  output logic             sr_en,
  output logic             mc_en,
  output logic             inv,
  output logic [RND_W-1:0] key_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned      WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [RND_W-1:0] NR_K    = RND_W'(NR);
  localparam logic [RND_W-1:0] ZERO_K  = '0;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARK, S_SB, S_SR, S_MC, S_DONE, S_ERR
  } state_t;

  state_t           state, state_n;
  logic [RND_W-1:0] round, round_n, key_n;
  logic             inv_n;
  logic [WD_W-1:0]  wdog, wdog_n;
  logic             step_active, step_done, adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      round   <= '0;
      key_idx <= '0;
      inv     <= 1'b0;
      wdog    <= '0;
    end else begin
      state   <= state_n;
      round   <= round_n;
      key_idx <= key_n;
      inv     <= inv_n;
      wdog    <= wdog_n;
    end
  end

  always_comb begin
    state_n     = state;
    round_n     = round;
    key_n       = key_idx;
    inv_n       = inv;
    step_active = 1'b0;
    step_done   = 1'b0;
    unique case (state)
      S_ARK:   begin step_active = 1'b1; step_done = ark_done; end
      S_SB:    begin step_active = 1'b1; step_done = sb_done;  end
      S_SR:    begin step_active = 1'b1; step_done = sr_done;  end
      S_MC:    begin step_active = 1'b1; step_done = mc_done;  end
      default: ;
    endcase
    // wdog is zero only in a step's entry cycle, so a stale done from the previous step is masked
    adv = step_active && (wdog != '0) && step_done;

    unique case (state)
      S_IDLE: if (start) begin
        inv_n   = decrypt;
        round_n = '0;
        key_n   = decrypt ? NR_K : '0;
        state_n = S_ARK;
      end
      S_ARK: if (adv) begin
        if (key_idx == (inv ? ZERO_K : NR_K)) begin
          state_n = S_DONE;
        end else if (!inv) begin
          round_n = round + 1'b1;
          state_n = S_SB;
        end else if (key_idx == NR_K) begin
          round_n = NR_K - 1'b1;
          state_n = S_SR;
        end else begin
          state_n = S_MC;
        end
      end
      S_SB: if (adv) begin
        if (inv) begin
          key_n   = round;
          state_n = S_ARK;
        end else begin
          state_n = S_SR;
        end
      end
      S_SR: if (adv) begin
        if (inv) begin
          state_n = S_SB;
        end else if (round == NR_K) begin
          key_n   = round;
          state_n = S_ARK;
        end else begin
          state_n = S_MC;
        end
      end
      S_MC: if (adv) begin
        if (inv) begin
          round_n = round - 1'b1;
          state_n = S_SR;
        end else begin
          key_n   = round;
          state_n = S_ARK;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (step_active && !adv && (wdog == WD_LAST)) state_n = S_ERR;
    wdog_n = (step_active && (state_n == state)) ? wdog + 1'b1 : '0;
  end

  assign ark_en = (state == S_ARK);
  assign sb_en  = (state == S_SB);
  assign sr_en  = (state == S_SR);
  assign mc_en  = (state == S_MC);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign err    = (state == S_ERR);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: emulated step units, expected step/key scoreboard,
// table of block vectors plus timeout, reset, and back-to-back sequences.
module tb_aes_round_sequencer;

  localparam int NR      = 10;
  localparam int RND_W   = 4;
  localparam int TIMEOUT = 15;

  localparam int ST_NONE = 0;
  localparam int ST_ARK  = 1;
  localparam int ST_SB   = 2;
  localparam int ST_SR   = 3;
  localparam int ST_MC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_drv = 1'b0, glitch_start = 1'b0;
  logic dec_drv = 1'b0, glitch_dec = 1'b0;
  logic start, decrypt;
  logic ark_done = 1'b0, sb_done = 1'b0, sr_done = 1'b0, mc_done = 1'b0;
  logic ark_en, sb_en, sr_en, mc_en, inv, busy, done, err;
  logic [RND_W-1:0] key_idx;

  assign start   = start_drv | glitch_start;
  assign decrypt = dec_drv ^ glitch_dec;

  aes_round_sequencer #(.NR(NR), .RND_W(RND_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .ark_done(ark_done), .sb_done(sb_done), .sr_done(sr_done), .mc_done(mc_done),
    .ark_en(ark_en), .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en),
    .inv(inv), .key_idx(key_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int step; int key; bit inv; } exp_t;
  typedef struct { bit dec; int lat; bit noise; bit glitch; int exp_edges; } vec_t;

  exp_t exp_q[$];
  int n_vec = 0, n_bad = 0;
  int cyc = 0;

  // unit-emulation controls, set by the main sequence
  int lat = 1;
  bit noise = 0, glitch = 0;
  int stall_sb = 0;

  // monitor-owned observations
  int cnt = 0, last_step = ST_NONE, sb_cnt = 0;
  int done_pulses = 0, err_pulses = 0, done_cyc = 0, err_cyc = 0, entry_cyc = 0;
  int err_ens = 0;

  task automatic check(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(int s, int k, bit i);
    exp_q.push_back('{step: s, key: k, inv: i});
  endfunction

  function automatic void build_seq(bit dec);
    if (!dec) begin
      push(ST_ARK, 0, 1'b0);
      for (int r = 1; r <= NR; r++) begin
        push(ST_SB, 0, 1'b0);
        push(ST_SR, 0, 1'b0);
        if (r != NR) push(ST_MC, 0, 1'b0);
        push(ST_ARK, r, 1'b0);
      end
    end else begin
      push(ST_ARK, NR, 1'b1);
      for (int r = NR - 1; r >= 0; r--) begin
        push(ST_SR, 0, 1'b1);
        push(ST_SB, 0, 1'b1);
        push(ST_ARK, r, 1'b1);
        if (r != 0) push(ST_MC, 0, 1'b1);
      end
    end
  endfunction

  function automatic int step_of();
    case ({ark_en, sb_en, sr_en, mc_en})
      4'b0000: return ST_NONE;
      4'b1000: return ST_ARK;
      4'b0100: return ST_SB;
      4'b0010: return ST_SR;
      4'b0001: return ST_MC;
      default: return 7;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor + scoreboard + unit responder, all on the falling edge
  initial forever begin
    int cur;
    bit stall;
    exp_t e;
    @(negedge clk);
    cur = step_of();
    if (cur != last_step) begin
      cnt = 0;
      if (cur != ST_NONE) begin
        entry_cyc = cyc;
        if (cur == ST_SB) sb_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_step", cur, ST_NONE);
        end else begin
          e = exp_q.pop_front();
          check("step", cur, e.step);
          check("inv", int'(inv), int'(e.inv));
          if (e.step == ST_ARK) check("key_idx", int'(key_idx), e.key);
        end
      end
    end else begin
      cnt++;
    end
    if (!busy) sb_cnt = 0;
    if (done) begin done_pulses++; done_cyc = cyc; end
    if (err) begin
      err_pulses++;
      err_cyc = cyc;
      err_ens = int'({ark_en, sb_en, sr_en, mc_en});
    end
    stall    = (cur == ST_SB) && (sb_cnt == stall_sb);
    ark_done = ((cur == ST_ARK) && cnt >= lat) || (noise && last_step == ST_ARK && cur != ST_ARK);
    sb_done  = (cur == ST_SB) && cnt >= lat && !stall;
    sr_done  = (cur == ST_SR) && cnt >= lat;
    mc_done  = ((cur == ST_MC) && cnt >= lat) || (noise && cur == ST_SB);
    glitch_start = glitch && (cur == ST_SB || cur == ST_SR) && ($urandom_range(0, 1) == 1);
    glitch_dec   = glitch && (cur != ST_NONE) && ($urandom_range(0, 1) == 1);
    last_step = cur;
  end

  task automatic kick(bit dec, output int t0);
    @(negedge clk);
    start_drv = 1'b1;
    dec_drv   = dec;
    @(posedge clk);
    #1 t0 = cyc;
  endtask

  task automatic run_block(vec_t v);
    int t0, d0, e0;
    lat = v.lat; noise = v.noise; glitch = v.glitch;
    build_seq(v.dec);
    d0 = done_pulses; e0 = err_pulses;
    kick(v.dec, t0);
    @(negedge clk);
    start_drv = 1'b0;
    dec_drv   = ~v.dec;
    for (int i = 0; i < 2000 && done_pulses == d0 && err_pulses == e0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("done_pulse", done_pulses - d0, 1);
    check("no_err", err_pulses - e0, 0);
    check("latency", done_cyc - t0, v.exp_edges);
    check("steps_left", exp_q.size(), 0);
    check("busy_after", int'(busy), 0);
    exp_q.delete();
    noise = 0; glitch = 0;
  endtask

  initial begin
    vec_t vecs[7];
    int t0, d0, e0, d1;
    vecs[0] = '{dec: 1'b0, lat: 1,  noise: 1'b0, glitch: 1'b0, exp_edges: 80};
    vecs[1] = '{dec: 1'b1, lat: 1,  noise: 1'b0, glitch: 1'b0, exp_edges: 80};
    vecs[2] = '{dec: 1'b0, lat: 2,  noise: 1'b0, glitch: 1'b0, exp_edges: 120};
    vecs[3] = '{dec: 1'b1, lat: 14, noise: 1'b0, glitch: 1'b0, exp_edges: 600};
    vecs[4] = '{dec: 1'b0, lat: 1,  noise: 1'b1, glitch: 1'b0, exp_edges: 80};
    vecs[5] = '{dec: 1'b1, lat: 1,  noise: 1'b0, glitch: 1'b1, exp_edges: 80};
    vecs[6] = '{dec: 1'b0, lat: 1,  noise: 1'b1, glitch: 1'b1, exp_edges: 80};

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", int'({ark_en, sb_en, sr_en, mc_en, busy, done, err, inv, key_idx}), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_block(vecs[i]);

    // SubBytes of round 3 never completes: watchdog abort
    stall_sb = 3;
    build_seq(1'b0);
    while (exp_q.size() > 10) void'(exp_q.pop_back());
    d0 = done_pulses; e0 = err_pulses;
    kick(1'b0, t0);
    @(negedge clk);
    start_drv = 1'b0;
    for (int i = 0; i < 200 && err_pulses == e0 && done_pulses == d0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("err_pulse", err_pulses - e0, 1);
    check("err_no_done", done_pulses - d0, 0);
    check("err_latency", err_cyc - t0, 33);
    check("sb_hold", err_cyc - entry_cyc, TIMEOUT);
    check("err_ens", err_ens, 0);
    check("err_steps_left", exp_q.size(), 0);
    check("err_busy_after", int'(busy), 0);
    exp_q.delete();
    stall_sb = 0;

    // reset during round 5, then a clean block
    build_seq(1'b0);
    d0 = done_pulses; e0 = err_pulses;
    kick(1'b0, t0);
    @(negedge clk);
    start_drv = 1'b0;
    for (int i = 0; i < 200 && sb_cnt < 5; i++) @(negedge clk);
    check("reached_round5", sb_cnt, 5);
    rst = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_outputs", int'({ark_en, sb_en, sr_en, mc_en, busy, done, err, inv, key_idx}), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_no_pulse", (done_pulses - d0) + (err_pulses - e0), 0);
    run_block(vecs[0]);

    // start held high: two separate back-to-back blocks
    lat = 1;
    build_seq(1'b0);
    build_seq(1'b0);
    d0 = done_pulses; e0 = err_pulses; d1 = 0;
    kick(1'b0, t0);
    for (int i = 0; i < 400 && done_pulses < d0 + 2 && err_pulses == e0; i++) begin
      @(negedge clk);
      if (done_pulses == d0 + 1 && d1 == 0) d1 = done_cyc;
    end
    start_drv = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_dones", done_pulses - d0, 2);
    check("b2b_no_err", err_pulses - e0, 0);
    check("b2b_first", d1 - t0, 80);
    check("b2b_gap", done_cyc - d1, 82);
    check("b2b_steps_left", exp_q.size(), 0);
    check("b2b_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
